cmd_fifo: RTL

Parametrised command/address/data queue that buffers bus transactions between a command producer (host/UART front end) and the register-bus master in the Mini-SOC. It is the first synchronous FIFO built on the shared `project_pkg` sizes. It generalises them into width- and depth-parametrised storage with a valid/ready handshake, first-word-fall-through reads, threshold flags, flush, and a high-water mark.

---
 rtl/project_pkg.sv | 17 +
 rtl/fifo_mem.sv | 24 ++
 rtl/cmd_fifo.sv | 124 ++++++++++++
 3 files changed

// File: rtl/project_pkg.sv
// Shared Mini-SOC sizes and the command packet layout used by the bus front end.
package project_pkg;

    localparam int DATA_SIZE  = 8;
    localparam int ADDR_SIZE  = 8;
    localparam int CMD_SIZE   = 3;
    localparam int FIFO_DEPTH = 8;

    typedef struct packed {
        logic [CMD_SIZE-1:0]  cmd;
        logic [ADDR_SIZE-1:0] addr;
        logic [DATA_SIZE-1:0] data;
    } cmd_pkt_t;

    localparam int PKT_W = $bits(cmd_pkt_t);

endpackage

// File: rtl/fifo_mem.sv
// Flop/distributed-RAM storage: clocked write, combinational read, no reset.
module fifo_mem #(
    parameter int unsigned WIDTH = 19,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/cmd_fifo.sv
// Command/address/data FIFO with valid/ready handshake, first-word-fall-through reads,
// threshold flags, flush and a high-water mark.
module cmd_fifo
    import project_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_SIZE,
    parameter int unsigned ADDR_W = ADDR_SIZE,
    parameter int unsigned CMD_W  = CMD_SIZE,
    parameter int unsigned DEPTH  = FIFO_DEPTH,
    parameter int unsigned AF_LVL = DEPTH - 2,
    parameter int unsigned AE_LVL = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [CMD_W-1:0]         wr_cmd,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [CMD_W-1:0]         rd_cmd,
    output logic [ADDR_W-1:0]        rd_addr,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   peak
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned PW = CMD_W + ADDR_W + DATA_W;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LVL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LVL);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
        $error("cmd_fifo: DEPTH must be a power of two and at least 2");
    end
    if ((AF_LVL < 1) || (AF_LVL > DEPTH)) begin : g_af_chk
        $error("cmd_fifo: AF_LVL must lie in 1..DEPTH");
    end
    if (AE_LVL > DEPTH - 1) begin : g_ae_chk
        $error("cmd_fifo: AE_LVL must lie in 0..DEPTH-1");
    end

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_peak;

    logic          w_wr_fire;
    logic          w_rd_fire;
    logic          w_clear;
    logic [CW-1:0] w_count_nxt;
    logic [PW-1:0] w_wr_pkt;
    logic [PW-1:0] w_rd_pkt;

    if ((DATA_W == DATA_SIZE) && (ADDR_W == ADDR_SIZE) && (CMD_W == CMD_SIZE)) begin : g_pkt_struct
        cmd_pkt_t w_wr_s;
        cmd_pkt_t w_rd_s;

        assign w_wr_s.cmd  = wr_cmd;
        assign w_wr_s.addr = wr_addr;
        assign w_wr_s.data = wr_data;
        assign w_wr_pkt    = w_wr_s;
        assign w_rd_s      = w_rd_pkt;
        assign rd_cmd      = w_rd_s.cmd;
        assign rd_addr     = w_rd_s.addr;
        assign rd_data     = w_rd_s.data;
    end else begin : g_pkt_flat
        assign w_wr_pkt = {wr_cmd, wr_addr, wr_data};
        assign {rd_cmd, rd_addr, rd_data} = w_rd_pkt;
    end

    // Handshakes depend only on registered count, never on the opposite side's request.
    assign wr_ready    = (r_count != DEPTH_C);
    assign rd_valid    = (r_count != '0);
    assign w_wr_fire   = wr_valid && wr_ready;
    assign w_rd_fire   = rd_valid && rd_ready;
    assign w_clear     = rst || flush;
    assign w_count_nxt = r_count + CW'(w_wr_fire) - CW'(w_rd_fire);

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_peak   <= '0;
        end else begin
            if (w_wr_fire) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_fire) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
            if (w_count_nxt > r_peak) begin
                r_peak <= w_count_nxt;
            end
        end
    end

    fifo_mem #(
        .WIDTH (PW),
        .DEPTH (DEPTH)
    ) u_mem (
        .i_clk   (clk),
        .i_we    (w_wr_fire && !w_clear),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wr_pkt),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_pkt)
    );

    assign count        = r_count;
    assign peak         = r_peak;
    assign almost_full  = (r_count >= AF_C);
    assign almost_empty = (r_count <= AE_C);

endmodule
